// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: FSM state encoding and counter-width helper shared by the
// PWM capture block and its input stage.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

  // Count registers are one bit wider than the generator resolution so a
  // full 2^NBITS period is representable.
  function automatic int unsigned cnt_w(input int unsigned nbits);
    return nbits + 1;
  endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: brings the asynchronous PWM line into the clk domain,
// optionally deglitches it, and produces single-cycle rise/fall pulses.
// Build option: define PWM_CAPTURE_FILTER_EN to insert the deglitch stage.
module pwm_capture_sync
  import pwm_capture_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  if (FILTER_LEN == 0 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("pwm_capture_sync: FILTER_LEN must be in 1..15");
  end

  logic [1:0] sync_q;
  logic       lvl;
  logic       prev_q;

  // Two-flop synchronizer; sync_q[1] is the synchronized level s.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic [3:0] flt_cnt_q;
  logic       flt_lvl_q;

  // Deglitch: the filtered level follows s only after FILTER_LEN consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_cnt_q <= 4'd0;
      flt_lvl_q <= 1'b0;
    end else if (sync_q[1] == flt_lvl_q) begin
      flt_cnt_q <= 4'd0;
    end else if (flt_cnt_q == 4'(FILTER_LEN - 1)) begin
      flt_lvl_q <= sync_q[1];
      flt_cnt_q <= 4'd0;
    end else begin
      flt_cnt_q <= flt_cnt_q + 4'd1;
    end
  end

  assign lvl = flt_lvl_q;
`else
  assign lvl = sync_q[1];
`endif

  // History flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= lvl;
    end
  end

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an external PWM line in clk
// cycles, publishes each complete period with a one-cycle valid strobe and
// raises a sticky timeout when no rising edge arrives in time.
// Build option: PWM_CAPTURE_FILTER_EN enables the input deglitch filter.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned NBITS      = 10,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pwm_in,
  output logic [cnt_w(NBITS)-1:0]    high_count,
  output logic [cnt_w(NBITS)-1:0]    period,
  output logic                       valid,
  output logic                       timeout
);

  localparam int unsigned     CntW   = cnt_w(NBITS);
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] x);
    return (x == CntMax) ? x : x + CntOne;
  endfunction

  logic rise;
  logic fall;

  pwm_capture_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  state_e          state_q,      state_d;
  logic [CntW-1:0] cnt_high_q,   cnt_high_d;
  logic [CntW-1:0] cnt_per_q,    cnt_per_d;
  logic [CntW-1:0] high_count_q, high_count_d;
  logic [CntW-1:0] period_q,     period_d;
  logic            valid_q,      valid_d;
  logic            timeout_q,    timeout_d;

  // State, counters and published results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_high_q   <= '0;
      cnt_per_q    <= '0;
      high_count_q <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_high_q   <= cnt_high_d;
      cnt_per_q    <= cnt_per_d;
      high_count_q <= high_count_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  // Measurement FSM: IDLE waits for a first rise (partial period discarded),
  // HIGH/LOW count one period and publish on the closing rise.
  always_comb begin
    state_d      = state_q;
    cnt_high_d   = cnt_high_q;
    cnt_per_d    = cnt_per_q;
    high_count_d = high_count_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;

    unique case (state_q)
      StIdle: begin
        cnt_high_d = '0;
        cnt_per_d  = '0;
        if (rise) begin
          cnt_high_d = CntOne;
          cnt_per_d  = CntOne;
          state_d    = StHigh;
        end
      end
      StHigh: begin
        // No rise can occur while the level is high, so saturation means stuck.
        if (cnt_per_q == CntMax) begin
          timeout_d  = 1'b1;
          cnt_high_d = '0;
          cnt_per_d  = '0;
          state_d    = StIdle;
        end else if (fall) begin
          cnt_per_d = sat_inc(cnt_per_q);
          state_d   = StLow;
        end else begin
          cnt_high_d = sat_inc(cnt_high_q);
          cnt_per_d  = sat_inc(cnt_per_q);
        end
      end
      StLow: begin
        // A rise on the saturating cycle still wins and reports period=MAX.
        if (rise) begin
          high_count_d = cnt_high_q;
          period_d     = cnt_per_q;
          valid_d      = 1'b1;
          timeout_d    = 1'b0;
          cnt_high_d   = CntOne;
          cnt_per_d    = CntOne;
          state_d      = StHigh;
        end else if (cnt_per_q == CntMax) begin
          timeout_d  = 1'b1;
          cnt_high_d = '0;
          cnt_per_d  = '0;
          state_d    = StIdle;
        end else begin
          cnt_per_d = sat_inc(cnt_per_q);
        end
      end
      default: begin
        cnt_high_d = '0;
        cnt_per_d  = '0;
        state_d    = StIdle;
      end
    endcase
  end

  assign high_count = high_count_q;
  assign period     = period_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture with NBITS=4. Stimulus
// pushes the expected (high_count, period) of every completed period; a
// monitor pops and compares on each valid strobe.
module tb_pwm_capture;

  localparam int unsigned NBITS = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int Lat   = 3 + 4;
  localparam int ThrLo = 4;
  localparam int ThrHi = 12;
`else
  localparam int Lat   = 3;
  localparam int ThrLo = 1;
  localparam int ThrHi = 15;
`endif

  typedef struct packed {
    logic [NBITS:0] hc;
    logic [NBITS:0] per;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           pwm_in;
  logic [NBITS:0] high_count;
  logic [NBITS:0] period;
  logic           valid;
  logic           timeout;

  pwm_capture #(
    .NBITS     (NBITS),
    .FILTER_LEN(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .high_count(high_count),
    .period    (period),
    .valid     (valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   prev_thr = -1;
  int   last_rise = 0;
  logic valid_d1 = 1'b0;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid strobe must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      n_vec++;
      if (valid_d1) begin
        n_err++;
        $display("FAIL valid_back_to_back: valid high on two consecutive cycles at cyc %0d", cyc);
      end else if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got hc=%0d per=%0d at cyc %0d, none expected",
                 high_count, period, cyc);
      end else begin
        e = sb_q.pop_front();
        if (high_count !== e.hc || period !== e.per || timeout !== 1'b0) begin
          n_err++;
          $display("FAIL result: got hc=%0d per=%0d to=%0b, want hc=%0d per=%0d to=0 (cyc %0d)",
                   high_count, period, timeout, e.hc, e.per, cyc);
        end
      end
    end
    valid_d1 = valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_prev();
    exp_t e;
    if (prev_thr >= 0) begin
      e.hc  = (NBITS + 1)'(prev_thr);
      e.per = (NBITS + 1)'(16);
      sb_q.push_back(e);
    end
  endtask

  // One 16-cycle generator period: high for thr cycles, optional extra pulse.
  task automatic run_period(input int thr, input int g_at, input int g_len);
    push_prev();
    last_rise = cyc;
    for (int i = 0; i < 16; i++) begin
      pwm_in = (i < thr) || (i >= g_at && i < g_at + g_len);
      @(negedge clk);
    end
    prev_thr = thr;
  endtask

  // Hold the current line level and check the timeout lands exactly 31 cycles
  // after the rise that started the last measurement was detected.
  task automatic check_timeout(input int d0, input string tag);
    while (cyc < d0 + Lat + 30) @(negedge clk);
    check({tag, "_timeout_pre"}, 32'(timeout), 32'd0);
    @(negedge clk);
    check({tag, "_timeout_set"}, 32'(timeout), 32'd1);
    check({tag, "_hc_held"}, 32'(high_count), 32'd5);
    check({tag, "_per_held"}, 32'(period), 32'd16);
    prev_thr = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_high_count", 32'(high_count), 32'd0);
    check("reset_period", 32'(period), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Steady stream, then threshold change and duty extremes.
    repeat (4) run_period(5, 0, 0);
    repeat (2) run_period(12, 0, 0);
    run_period(ThrLo, 0, 0);
    run_period(ThrHi, 0, 0);
    repeat (2) run_period(5, 0, 0);

    // Line stuck low.
    check_timeout(last_rise, "low");
    repeat (2) run_period(5, 0, 0);

    // Line stuck high.
    push_prev();
    d0     = cyc;
    pwm_in = 1'b1;
    check_timeout(d0, "high");
    pwm_in = 1'b0;
    repeat (8) @(negedge clk);
    repeat (2) run_period(6, 0, 0);

    // Reset three cycles after a detected rise.
    push_prev();
    for (int i = 0; i < 16; i++) begin
      pwm_in = (i < 5);
      if (i == Lat + 2) rst = 1'b1;
      if (i == Lat + 3) begin
        check("rst_high_count", 32'(high_count), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
      end
      @(negedge clk);
    end
    prev_thr = -1;
    repeat (3) run_period(5, 0, 0);

`ifdef PWM_CAPTURE_FILTER_EN
    // Short glitch in the low phase must be discarded.
    run_period(5, 10, 2);
`endif
    run_period(5, 0, 0);
    run_period(5, 0, 0);
    repeat (Lat + 4) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
